// File: rtl/boundary_param_ctrl_pkg.sv
// Shared types and constants for the rotated-overlay parameter controller:
// FSM encoding, coordinate/angle widths and the corner-delta helper.
package boundary_param_ctrl_pkg;

  localparam int COORD_W    = 11;
  localparam int OFFS_W     = 12;
  localparam int THETA_W    = 10;
  localparam int STALE_W    = 8;
  localparam int ANGLE_FULL = 360;
  localparam int ANGLE_HALF = 180;
  localparam int IDX_X      = 0;
  localparam int IDX_Y      = 1;

  localparam logic [STALE_W-1:0] STALE_MAX = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_COMMIT  = 2'd2
  } state_e;

  typedef logic [1:0][COORD_W-1:0] coord_t;

  // Zero-extend both operands so the difference of two unsigned coordinates is a proper signed offset.
  function automatic logic signed [OFFS_W-1:0] coord_delta(input logic [COORD_W-1:0] from_c,
                                                          input logic [COORD_W-1:0] to_c);
    return $signed({1'b0, to_c}) - $signed({1'b0, from_c});
  endfunction

endpackage

// File: rtl/boundary_param_ctrl_if.sv
// Corner-detector, arctan-LUT and overlay-parameter signals of the controller.
// master = controller side, slave = surrounding datapath.
interface boundary_param_ctrl_if;
  import boundary_param_ctrl_pkg::*;

  logic [COORD_W-1:0]        VGA_X;
  logic [COORD_W-1:0]        VGA_Y;
  logic                      corner_valid;
  logic [COORD_W-1:0]        top_left_x;
  logic [COORD_W-1:0]        top_left_y;
  logic [COORD_W-1:0]        top_right_x;
  logic [COORD_W-1:0]        top_right_y;
  logic signed [OFFS_W-1:0]  atan_numer;
  logic signed [OFFS_W-1:0]  atan_denom;
  logic signed [THETA_W-1:0] atan_theta;
  logic [COORD_W-1:0]        draw_start_x;
  logic [COORD_W-1:0]        draw_start_y;
  logic [COORD_W-1:0]        draw_end_x;
  logic [COORD_W-1:0]        draw_end_y;
  logic signed [THETA_W-1:0] theta;
  logic                      params_valid;
  logic                      busy;

  modport master (
    input  VGA_X, VGA_Y, corner_valid, top_left_x, top_left_y, top_right_x, top_right_y, atan_theta,
    output atan_numer, atan_denom, draw_start_x, draw_start_y, draw_end_x, draw_end_y,
           theta, params_valid, busy
  );

  modport slave (
    output VGA_X, VGA_Y, corner_valid, top_left_x, top_left_y, top_right_x, top_right_y, atan_theta,
    input  atan_numer, atan_denom, draw_start_x, draw_start_y, draw_end_x, draw_end_y,
           theta, params_valid, busy
  );

endinterface

// File: rtl/boundary_param_ctrl_angle_hysteresis.sv
// Wrap-around angular distance between a candidate and the committed theta;
// asserts update_o when the change is large enough or nothing valid is committed yet.
module boundary_param_ctrl_angle_hysteresis
  import boundary_param_ctrl_pkg::*;
#(
  parameter int p_theta_hyst = 2
) (
  input  logic signed [THETA_W-1:0] new_theta_i,
  input  logic signed [THETA_W-1:0] cur_theta_i,
  input  logic                      cur_valid_i,
  output logic                      update_o
);

  logic signed [THETA_W:0] diff_s;
  logic [THETA_W:0]        abs_s;
  logic [THETA_W:0]        dist_s;

  // Shortest distance around the circle, then threshold against the hysteresis band.
  always_comb begin
    diff_s = $signed({new_theta_i[THETA_W-1], new_theta_i}) - $signed({cur_theta_i[THETA_W-1], cur_theta_i});
    if (diff_s[THETA_W]) begin
      abs_s = $unsigned(-diff_s);
    end else begin
      abs_s = $unsigned(diff_s);
    end
    if (abs_s > 11'(ANGLE_HALF)) begin
      dist_s = 11'(ANGLE_FULL) - abs_s;
    end else begin
      dist_s = abs_s;
    end
    update_o = !cur_valid_i || (dist_s >= 11'(p_theta_hyst));
  end

endmodule

// File: rtl/boundary_param_ctrl.sv
// Captures detector corners, runs them through the external arctan LUT and
// commits draw window + theta atomically once per frame at the first vblank line.
module boundary_param_ctrl
  import boundary_param_ctrl_pkg::*;
#(
  parameter int p_image_width  = 80,
  parameter int p_commit_line  = 480,
  parameter int p_atan_latency = 2,
  parameter int p_theta_hyst   = 2,
  parameter int p_stale_frames = 30,
  parameter int p_default_x    = 300,
  parameter int p_default_y    = 200
) (
  input logic                  clk,
  input logic                  reset,
  boundary_param_ctrl_if.master bus
);

  localparam logic [7:0] LAT_LAST = 8'(p_atan_latency);

  state_e                    state_q, state_d;
  logic [COORD_W-1:0]        vga_y_prev_q;
  logic                      pend_q, pend_d;
  coord_t                    pend_tl_q, pend_tl_d, pend_tr_q, pend_tr_d;
  coord_t                    snap_tl_q, snap_tl_d, snap_tr_q, snap_tr_d;
  logic signed [OFFS_W-1:0]  numer_q, numer_d, denom_q, denom_d;
  logic [7:0]                cnt_q, cnt_d;
  logic signed [THETA_W-1:0] theta_new_q, theta_new_d;
  logic [STALE_W-1:0]        stale_q, stale_d;
  coord_t                    start_q, start_d, end_q, end_d;
  logic signed [THETA_W-1:0] theta_q, theta_d;
  logic                      pv_q, pv_d;
  logic                      busy_q, busy_d;
  logic                      commit_evt_s;
  logic                      upd_s;

  assign commit_evt_s = (bus.VGA_Y == 11'(p_commit_line)) && (vga_y_prev_q != 11'(p_commit_line));

  boundary_param_ctrl_angle_hysteresis #(
    .p_theta_hyst(p_theta_hyst)
  ) u_hyst (
    .new_theta_i(theta_new_q),
    .cur_theta_i(theta_q),
    .cur_valid_i(pv_q),
    .update_o   (upd_s)
  );

  // Corner capture plus IDLE/COMPUTE/COMMIT sequencing.
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    pend_tl_d   = pend_tl_q;
    pend_tr_d   = pend_tr_q;
    snap_tl_d   = snap_tl_q;
    snap_tr_d   = snap_tr_q;
    numer_d     = numer_q;
    denom_d     = denom_q;
    cnt_d       = cnt_q;
    theta_new_d = theta_new_q;
    stale_d     = stale_q;
    start_d     = start_q;
    end_d       = end_q;
    theta_d     = theta_q;
    pv_d        = pv_q;

    if (bus.corner_valid) begin
      pend_d           = 1'b1;
      pend_tl_d[IDX_X] = bus.top_left_x;
      pend_tl_d[IDX_Y] = bus.top_left_y;
      pend_tr_d[IDX_X] = bus.top_right_x;
      pend_tr_d[IDX_Y] = bus.top_right_y;
    end else begin
      pend_d = pend_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (commit_evt_s && pend_q) begin
          state_d   = ST_COMPUTE;
          snap_tl_d = pend_tl_q;
          snap_tr_d = pend_tr_q;
          denom_d   = coord_delta(pend_tl_q[IDX_X], pend_tr_q[IDX_X]);
          numer_d   = coord_delta(pend_tl_q[IDX_Y], pend_tr_q[IDX_Y]);
          cnt_d     = 8'd0;
          // A sample arriving on this very edge must survive for the next frame.
          pend_d    = bus.corner_valid;
        end else if (commit_evt_s) begin
          stale_d = (stale_q == STALE_MAX) ? stale_q : stale_q + 8'd1;
          if (stale_d >= 8'(p_stale_frames)) begin
            pv_d = 1'b0;
          end else begin
            pv_d = pv_q;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COMPUTE: begin
        if (cnt_q == LAT_LAST) begin
          state_d     = ST_COMMIT;
          theta_new_d = bus.atan_theta;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
        if ((numer_q == 12'sd0) && (denom_q == 12'sd0)) begin
          pv_d = pv_q;
        end else begin
          start_d = snap_tl_q;
          end_d   = snap_tr_q;
          pv_d    = 1'b1;
          stale_d = 8'd0;
          if (upd_s) begin
            theta_d = theta_new_q;
          end else begin
            theta_d = theta_q;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset restores the power-on overlay window.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      vga_y_prev_q   <= 11'd0;
      pend_q         <= 1'b0;
      pend_tl_q      <= '0;
      pend_tr_q      <= '0;
      snap_tl_q      <= '0;
      snap_tr_q      <= '0;
      numer_q        <= 12'sd0;
      denom_q        <= 12'sd0;
      cnt_q          <= 8'd0;
      theta_new_q    <= 10'sd0;
      stale_q        <= 8'd0;
      start_q[IDX_X] <= 11'(p_default_x);
      start_q[IDX_Y] <= 11'(p_default_y);
      end_q[IDX_X]   <= 11'(p_default_x + p_image_width);
      end_q[IDX_Y]   <= 11'(p_default_y);
      theta_q        <= 10'sd0;
      pv_q           <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      vga_y_prev_q <= bus.VGA_Y;
      pend_q       <= pend_d;
      pend_tl_q    <= pend_tl_d;
      pend_tr_q    <= pend_tr_d;
      snap_tl_q    <= snap_tl_d;
      snap_tr_q    <= snap_tr_d;
      numer_q      <= numer_d;
      denom_q      <= denom_d;
      cnt_q        <= cnt_d;
      theta_new_q  <= theta_new_d;
      stale_q      <= stale_d;
      start_q      <= start_d;
      end_q        <= end_d;
      theta_q      <= theta_d;
      pv_q         <= pv_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.atan_numer   = numer_q;
  assign bus.atan_denom   = denom_q;
  assign bus.draw_start_x = start_q[IDX_X];
  assign bus.draw_start_y = start_q[IDX_Y];
  assign bus.draw_end_x   = end_q[IDX_X];
  assign bus.draw_end_y   = end_q[IDX_Y];
  assign bus.theta        = theta_q;
  assign bus.params_valid = pv_q;
  assign bus.busy         = busy_q;

endmodule
